// File: rtl/demux16_router_if.sv
// Handshake bundle for demux16_router: one producer-facing input channel,
// two consumer-facing output channels and the per-output transfer counters.
interface demux16_router_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Environment side: the producer and both consumers.
  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Router side.
  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux16_router.sv
// 1-to-2 registered demultiplexer: each accepted word lands in the one-entry
// holding register of the output chosen by in_sel, with per-output counters.
module demux16_router #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  demux16_router_if.slave bus
);

  logic [1:0]            valid_q;
  logic [1:0][WIDTH-1:0] data_q;
  logic [1:0][CNT_W-1:0] cnt_q;

  logic [1:0] ready;
  logic [1:0] free;
  logic [1:0] take;
  logic [1:0] load;
  logic       in_ready_c;

  // A slot is free when empty or being drained this cycle, so a full slot
  // can reload on the same edge it empties (one word per cycle per output).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    load       = '0;
    ready      = {bus.out1_ready, bus.out0_ready};
    free       = ~valid_q | ready;
    take       = valid_q & ready;
    in_ready_c = bus.in_sel ? free[1] : free[0];
    if (bus.in_valid && in_ready_c) begin
      load = bus.in_sel ? 2'b10 : 2'b01;
    end
  end

  // NOTE: the holding registers are reset as well because reset must clear the visible output data, not just the valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.in_data;
        end else if (take[k]) begin
          valid_q[k] <= 1'b0;
        end
        if (take[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = valid_q[0];
  assign bus.out0_data  = data_q[0];
  assign bus.out1_valid = valid_q[1];
  assign bus.out1_data  = data_q[1];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];

endmodule
